// File: rtl/floppy_sdram_pkg.sv
// Shared constants for the floppy SDRAM window port: FSM encoding, byte lanes, byte enables.
package floppy_sdram_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_BOTH = 2'b11;

  function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic lane);
    return (lane == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/floppy_sdram_rcache.sv
// One-word read cache for the floppy SDRAM port; only built with FLOPPY_SDRAM_RCACHE_EN.
module floppy_sdram_rcache
  import floppy_sdram_pkg::*;
#(
  parameter int MEM_AW = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MEM_AW-1:0] lookup_addr,
  output logic              hit,
  output logic [15:0]       hit_data,
  input  logic              fill,
  input  logic [MEM_AW-1:0] fill_addr,
  input  logic [15:0]       fill_data,
  input  logic              wr_upd,
  input  logic [MEM_AW-1:0] wr_addr,
  input  logic              wr_lane,
  input  logic [7:0]        wr_byte
);

  logic              valid;
  logic [MEM_AW-1:0] tag;
  logic [15:0]       data;

  assign hit      = valid && (tag == lookup_addr);
  assign hit_data = data;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      data  <= fill_data;
    end else if (wr_upd && valid && (tag == wr_addr)) begin
      // keep the cached word coherent with the write that is heading to SDRAM
      if (wr_lane == LANE_HI) data[15:8] <= wr_byte;
      else                    data[7:0]  <= wr_byte;
    end
  end

endmodule

// File: rtl/floppy_sdram_port.sv
// Byte-wide floppy SDRAM window responder: turns rd/wr strobes into 16-bit word requests.
// Optional one-word read cache enabled by defining FLOPPY_SDRAM_RCACHE_EN.
//
// state   | meaning
// IDLE    | ready to accept a new rd/wr strobe
// WAIT    | mem_req high, waiting for mem_ack
module floppy_sdram_port
  import floppy_sdram_pkg::*;
#(
  parameter int                MEM_AW    = 22,
  parameter logic [MEM_AW-1:0] BASE_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [22:0]       addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  input  logic              rd,
  input  logic              wr,
  output logic              busy,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  localparam int SW = (MEM_AW > 22) ? MEM_AW : 22;

  logic [0:0]        state;
  logic              rd_lane;
  logic [SW-1:0]     word_sum;
  logic [MEM_AW-1:0] word_addr;
  logic              idle;
  logic              cache_hit;
  logic [15:0]       cache_data;

  // word address wraps modulo 2^MEM_AW
  assign word_sum  = SW'(BASE_WORD) + SW'(addr[22:1]);
  assign word_addr = word_sum[MEM_AW-1:0];
  assign idle      = (state == ST_IDLE);
  assign busy      = rd | wr | !idle;

`ifdef FLOPPY_SDRAM_RCACHE_EN
  floppy_sdram_rcache #(.MEM_AW(MEM_AW)) u_rcache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (word_addr),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill        (!idle && mem_ack && !mem_we),
    .fill_addr   (mem_addr),
    .fill_data   (mem_rdata),
    .wr_upd      (idle && wr),
    .wr_addr     (word_addr),
    .wr_lane     (addr[0]),
    .wr_byte     (wdata)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= 16'h0000;
      rdata     <= 8'h00;
      rd_lane   <= LANE_LO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr) begin
            mem_addr  <= word_addr;
            mem_we    <= 1'b1;
            mem_wdata <= {wdata, wdata};
            mem_be    <= addr[0] ? BE_HI : BE_LO;
            mem_req   <= 1'b1;
            state     <= ST_WAIT;
          end else if (rd) begin
            if (cache_hit) begin
              rdata <= lane_sel(cache_data, addr[0]);
            end else begin
              mem_addr <= word_addr;
              mem_we   <= 1'b0;
              mem_be   <= BE_BOTH;
              mem_req  <= 1'b1;
              rd_lane  <= addr[0];
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // strobes here are protocol violations and are dropped
          if (mem_ack) begin
            if (!mem_we) rdata <= lane_sel(mem_rdata, rd_lane);
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 2'b00;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floppy_sdram_port.sv
// Directed self-checking bench for floppy_sdram_port (default and wrapped-base instances).
module tb_floppy_sdram_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rd, wr, busy;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_we, mem_req, mem_ack;
  logic [15:0] mem_rdata;

  logic [7:0]  w_rdata;
  logic        w_rd, w_busy;
  logic [21:0] w_mem_addr;
  logic [15:0] w_mem_wdata;
  logic [1:0]  w_mem_be;
  logic        w_mem_we, w_mem_req, w_mem_ack;

  int tests = 0;
  int fails = 0;
  int req_cnt = 0;
  int req_base;
  logic req_q = 1'b0;

  always #5 clk = ~clk;

  floppy_sdram_port dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rd(rd), .wr(wr), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  floppy_sdram_port #(.MEM_AW(22), .BASE_WORD(22'h3FFFFF)) dut_w (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rdata(w_rdata),
    .rd(w_rd), .wr(1'b0), .busy(w_busy), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .mem_be(w_mem_be), .mem_we(w_mem_we), .mem_req(w_mem_req), .mem_ack(w_mem_ack),
    .mem_rdata(16'h0000)
  );

  always @(posedge clk) begin
    if (mem_req && !req_q) req_cnt++;
    req_q <= mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // read on the default instance; one WAIT cycle before ack when a request is expected
  task automatic do_read(input string tag, input logic [22:0] a, input logic [15:0] word,
                         input logic expect_req);
    addr = a; rd = 1'b1;
    #1 chk({tag, "_busy_strobe"}, busy, 1);
    tick();
    rd = 1'b0;
    #1;
    if (expect_req) begin
      chk({tag, "_req"}, mem_req, 1);
      chk({tag, "_be"}, mem_be, 2'b11);
      chk({tag, "_we"}, mem_we, 0);
      tick();
      mem_rdata = word; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1 chk({tag, "_busy_done"}, busy, 0);
    end else begin
      chk({tag, "_noreq"}, mem_req, 0);
      chk({tag, "_busy_1cyc"}, busy, 0);
    end
  endtask

  task automatic do_write(input string tag, input logic [22:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    #1 chk({tag, "_req"}, mem_req, 1);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1 chk({tag, "_req_done"}, mem_req, 0);
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; rd = 0; wr = 0; mem_ack = 0; mem_rdata = '0;
    w_rd = 0; w_mem_ack = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_be", mem_be, 2'b00);

    // write with ack four cycles after acceptance
    addr = 23'h012345; wdata = 8'hA5; wr = 1'b1;
    #1 chk("wr_busy_strobe", busy, 1);
    tick();
    wr = 1'b0;
    #1;
    chk("wr_addr", mem_addr, 22'h0091A2);
    chk("wr_be", mem_be, 2'b10);
    chk("wr_wdata", mem_wdata, 16'hA5A5);
    chk("wr_we", mem_we, 1);
    chk("wr_req", mem_req, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_busy_wait", busy, 1);
      chk("wr_addr_stable", mem_addr, 22'h0091A2);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("wr_busy_done", busy, 0);
    chk("wr_req_done", mem_req, 0);
    chk("wr_we_done", mem_we, 0);
    chk("wr_be_done", mem_be, 2'b00);
    chk("wr_rdata_keep", rdata, 8'h00);

    // read lanes
    addr = 23'h000010; rd = 1'b1;
    tick();
    rd = 1'b0;
    #1 chk("rd_lo_addr", mem_addr, 22'h000008);
    do_read("rd_lo_tail", 23'h000010, 16'hBEEF, 1'b1);
    chk("rd_lo_rdata", rdata, 8'hEF);
    do_read("rd_hi", 23'h000011, 16'hBEEF, 1'b1);
    chk("rd_hi_rdata", rdata, 8'hBE);
    do_write("wr_after_rd", 23'h000040, 8'h77);
    chk("wr_keeps_rdata", rdata, 8'hBE);

    // rd and wr together -> write on low lane
    addr = 23'h000050; wdata = 8'h3C; rd = 1'b1; wr = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b0;
    #1;
    chk("rdwr_we", mem_we, 1);
    chk("rdwr_be", mem_be, 2'b01);
    chk("rdwr_wdata", mem_wdata, 16'h3C3C);
    mem_rdata = 16'h9999; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1 chk("rdwr_rdata_keep", rdata, 8'hBE);

    // ack while idle is ignored
    mem_rdata = 16'h5555; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1 chk("idle_ack_rdata", rdata, 8'hBE);
    chk("idle_ack_req", mem_req, 0);

    // wrap on the BASE_WORD=3FFFFF instance
    addr = 23'h000002; w_rd = 1'b1;
    tick();
    w_rd = 1'b0;
    #1 chk("wrap_addr", w_mem_addr, 22'h000000);
    w_mem_ack = 1'b1;
    tick();
    w_mem_ack = 1'b0;
    addr = 23'h7FFFFF; w_rd = 1'b1;
    tick();
    w_rd = 1'b0;
    #1 chk("wrap_top_addr", w_mem_addr, 22'h3FFFFE);
    w_mem_ack = 1'b1;
    tick();
    w_mem_ack = 1'b0;
    #1 chk("wrap_busy_done", w_busy, 0);

    // rd during WAIT ignored, then reset mid-WAIT and a stale ack
    addr = 23'h000030; rd = 1'b1;
    tick();
    addr = 23'h000041;
    tick();
    rd = 1'b0;
    #1 chk("wait_rd_addr", mem_addr, 22'h000018);
    chk("wait_rd_req", mem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("midreset_req", mem_req, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_rdata", rdata, 8'h00);
    mem_rdata = 16'h1234; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1 chk("stale_ack_rdata", rdata, 8'h00);
    chk("stale_ack_req", mem_req, 0);
    chk("stale_ack_busy", busy, 0);

    req_base = req_cnt;
`ifdef FLOPPY_SDRAM_RCACHE_EN
    do_read("c_miss", 23'h000020, 16'hCAFE, 1'b1);
    chk("c_miss_rdata", rdata, 8'hFE);
    do_read("c_hit_lo", 23'h000020, 16'h0000, 1'b0);
    chk("c_hit_lo_rdata", rdata, 8'hFE);
    do_read("c_hit_hi", 23'h000021, 16'h0000, 1'b0);
    chk("c_hit_hi_rdata", rdata, 8'hCA);
    chk("c_one_req", req_cnt - req_base, 1);
    do_write("c_wr", 23'h000021, 8'h11);
    do_read("c_hit_upd", 23'h000021, 16'h0000, 1'b0);
    chk("c_hit_upd_rdata", rdata, 8'h11);
    chk("c_req_total", req_cnt - req_base, 2);
`else
    do_read("nc_rd0", 23'h000020, 16'hCAFE, 1'b1);
    chk("nc_rd0_rdata", rdata, 8'hFE);
    do_read("nc_rd1", 23'h000020, 16'hCAFE, 1'b1);
    do_read("nc_rd2", 23'h000021, 16'hCAFE, 1'b1);
    chk("nc_rd2_rdata", rdata, 8'hCA);
    chk("nc_three_req", req_cnt - req_base, 3);
    do_write("nc_wr", 23'h000021, 8'h11);
    do_read("nc_rd3", 23'h000021, 16'h11FE, 1'b1);
    chk("nc_rd3_rdata", rdata, 8'h11);
    chk("nc_req_total", req_cnt - req_base, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/floppy_sdram_port.md
Name: floppy_sdram_port

Overview:
Responder end of the floppy controller's SDRAM window request interface (byte address, rd/wr strobe, busy).
- Converts each byte access into one request on a 16-bit-word SDRAM controller port with byte enables.
- Holds busy until the access retires, and returns read bytes.
- Sits between the floppy 6502 subsystem and the SDRAM arbiter.

Parameters:
MEM_AW, 22, word-address width of the SDRAM controller port
BASE_WORD, 22'h000000, word offset added to every request; places the floppy window inside SDRAM

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
addr  in  23  byte address from requester, {page, offset}
wdata  in  8  write byte from requester
rdata  out  8  read byte to requester
rd  in  1  read strobe, one-cycle pulse
wr  in  1  write strobe, one-cycle pulse
busy  out  1  access in progress
mem_addr  out  MEM_AW  word address to SDRAM controller
mem_wdata  out  16  write word
mem_be  out  2  byte enables, bit0 = [7:0]
mem_we  out  1  1 = write request
mem_req  out  1  request, level; held until mem_ack
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid with it
mem_rdata  in  16  read word

Behaviour:
- One clock (clk). Synchronous active-high reset (reset).
- Reset values:
  - state IDLE
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata all 0
  - rdata 8'h00
  - busy 0 once rd/wr are low
- States:
  - IDLE: accepts a new access.
  - WAIT: mem_req is high; waiting for mem_ack.
- busy = rd | wr | (state != IDLE), combinational.
  - Required because the requester samples busy on the cycle after its strobe.
  - busy must be high in the same cycle as the strobe.
- Strobe accepted in IDLE at edge k:
  - latch mem_addr = BASE_WORD + addr[22:1], truncated to MEM_AW bits (wraps).
  - byte lane = addr[0]; lane 0 = [7:0], lane 1 = [15:8].
  - write: mem_we=1, mem_wdata={wdata,wdata}, mem_be = addr[0] ? 2'b10 : 2'b01.
  - read: mem_we=0, mem_be=2'b11.
  - mem_req=1 from k; state→WAIT.
- WAIT, mem_ack at edge m:
  - mem_req→0, mem_we→0, mem_be→0; state→IDLE.
  - on a read, rdata ← selected lane of mem_rdata.
  - busy falls after m. Minimum busy length is 2 cycles (strobe cycle plus one WAIT cycle).
- mem_addr, mem_wdata, mem_be and mem_we are stable for the whole time mem_req is high.
- rdata holds its last read value until the next read retires. Writes never change rdata.
- Boundary cases:
  - rd and wr together: treated as a write.
  - rd or wr while in WAIT: ignored (protocol violation).
  - mem_ack in IDLE: ignored.
  - mem_ack in the same cycle as acceptance: cannot occur, because mem_req is not yet high.
  - reset mid-WAIT: returns to IDLE with mem_req=0; the access is abandoned, and a stale mem_ack after reset is ignored.
  - addr=23'h7FFFFF with BASE_WORD>0: word address wraps modulo 2^MEM_AW.

Optional Feature:
FLOPPY_SDRAM_RCACHE_EN
- Defined: a one-word read cache (valid bit, tag = full word address, 16-bit data).
  - Read hit in IDLE at edge k: rdata ← cached lane at k, no mem_req, state stays IDLE; busy is high only in the strobe cycle.
  - Read miss: normal access; the cache fills on mem_ack.
  - Write whose tag matches: the matching cache byte is updated and the write still goes to SDRAM.
  - reset clears the valid bit.
- Undefined: every read goes to SDRAM; no cache state.

Decomposition:
- Package floppy_sdram_pkg holds:
  - state encoding (ST_IDLE, ST_WAIT)
  - lane constants (LANE_LO=0, LANE_HI=1)
  - BE constants (BE_LO=2'b01, BE_HI=2'b10, BE_BOTH=2'b11)
- Cache logic goes in sub-module floppy_sdram_rcache, instantiated only under FLOPPY_SDRAM_RCACHE_EN. The main FSM stays in floppy_sdram_port.

Test Plan:
1. Reset held 3 cycles, then released -> mem_req=0, busy=0, rdata=8'h00.
2. wr pulse, addr=23'h012345, wdata=8'hA5, ack 4 cycles later -> mem_addr=22'h0091A2, mem_be=2'b10, mem_wdata=16'hA5A5, mem_we=1; busy high from the strobe cycle until the ack edge.
3. rd addr=23'h000010, mem_rdata=16'hBEEF with ack -> rdata=8'hEF; repeat with addr=23'h000011 -> rdata=8'hBE; then a write -> rdata remains 8'hBE.
4. BASE_WORD=22'h3FFFFF, rd addr=23'h000002 -> mem_addr=22'h000000 (wrap).
5. rd during WAIT, and reset asserted mid-WAIT followed by a late mem_ack -> extra rd ignored; after reset, state IDLE, mem_req=0, rdata unchanged by the late ack.
6. With FLOPPY_SDRAM_RCACHE_EN: two reads to 23'h000020, then 23'h000021 -> one mem_req only; second and third reads have busy high for 1 cycle; wr 8'h11 to 23'h000021 then rd -> rdata=8'h11, no mem_req on that rd.
